// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and constants for the IF/DM single-port SRAM arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_e;

    localparam logic [3:0] WEB_NONE = 4'b1111;
    localparam logic [3:0] WEB_BYTE = 4'b1110;
    localparam logic [3:0] WEB_HALF = 4'b1100;
    localparam logic [3:0] WEB_WORD = 4'b0000;

    function automatic logic is_read(input logic [3:0] web);
        return web == WEB_NONE;
    endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester and SRAM-side bus of the arbiter; slave = arbiter, master = core + SRAM macro.
interface sram_port_arbiter_if #(
    parameter int ADDR_W  = 16,
    parameter int SRAM_AW = 14
);
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_gnt_o;
    logic              if_rvalid_o;
    logic [31:0]       if_rdata_o;

    logic              dm_req_i;
    logic [ADDR_W-1:0] dm_addr_i;
    logic [3:0]        dm_web_i;
    logic [31:0]       dm_wdata_i;
    logic              dm_gnt_o;
    logic              dm_rvalid_o;
    logic [31:0]       dm_rdata_o;

    logic               sram_cs_o;
    logic               sram_oe_o;
    logic [3:0]         sram_web_o;
    logic [SRAM_AW-1:0] sram_addr_o;
    logic [31:0]        sram_di_o;
    logic [31:0]        sram_do_i;

    logic              stall_o;

    modport slave (
        input  if_req_i, if_addr_i,
        input  dm_req_i, dm_addr_i, dm_web_i, dm_wdata_i,
        input  sram_do_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o,
        output dm_gnt_o, dm_rvalid_o, dm_rdata_o,
        output sram_cs_o, sram_oe_o, sram_web_o, sram_addr_o, sram_di_o,
        output stall_o
    );

    modport master (
        output if_req_i, if_addr_i,
        output dm_req_i, dm_addr_i, dm_web_i, dm_wdata_i,
        output sram_do_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o,
        input  dm_gnt_o, dm_rvalid_o, dm_rdata_o,
        input  sram_cs_o, sram_oe_o, sram_web_o, sram_addr_o, sram_di_o,
        input  stall_o
    );

endinterface

// File: rtl/sram_port_arbiter_streak_ctr.sv
// Priority decision between IF and DM with a saturating DM-streak counter that
// hands the port to IF once DM has won MAX_DM_STREAK contended cycles in a row.
module arb_streak_ctr #(
    parameter int MAX_DM_STREAK = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic dm_req,
    output logic if_gnt,
    output logic dm_gnt
);

    localparam int SW = $clog2(MAX_DM_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);

    logic [SW-1:0] streak_q;

    assign if_gnt = if_req & (~dm_req | (streak_q == STREAK_MAX));
    assign dm_gnt = dm_req & ~if_gnt;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak_q <= '0;
        end else if (dm_gnt && if_req) begin
            if (streak_q != STREAK_MAX) streak_q <= streak_q + 1'b1;
        end else begin
            streak_q <= '0;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port synchronous SRAM between instruction fetch and load/store,
// returning read data the cycle after grant and stalling the core while anything is pending.
module sram_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W        = 16,
    parameter int SRAM_AW       = 14,
    parameter int MAX_DM_STREAK = 4
) (
    input logic          clk,
    input logic          rst,
    sram_port_arbiter_if.slave bus
);

    logic        if_gnt;
    logic        dm_gnt;
    owner_e      owner_q;
    owner_e      owner_d;
    logic [31:0] if_rdata_q;
    logic [31:0] dm_rdata_q;

    // Byte-lane bits never reach the word-addressed SRAM.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.if_addr_i[1:0], bus.dm_addr_i[1:0]};

    arb_streak_ctr #(.MAX_DM_STREAK(MAX_DM_STREAK)) u_streak_ctr (
        .clk    (clk),
        .rst    (rst),
        .if_req (bus.if_req_i),
        .dm_req (bus.dm_req_i),
        .if_gnt (if_gnt),
        .dm_gnt (dm_gnt)
    );

    always_comb begin
        // NOTE: every output gets a default up front so no path leaves one unassigned (no latch).
        bus.sram_cs_o   = 1'b0;
        bus.sram_oe_o   = 1'b0;
        bus.sram_web_o  = WEB_NONE;
        bus.sram_addr_o = '0;
        bus.sram_di_o   = '0;
        owner_d         = OWN_NONE;
        if (if_gnt) begin
            bus.sram_cs_o   = 1'b1;
            bus.sram_oe_o   = 1'b1;
            bus.sram_addr_o = bus.if_addr_i[SRAM_AW+1:2];
            owner_d         = OWN_IF;
        end else if (dm_gnt) begin
            bus.sram_cs_o   = 1'b1;
            bus.sram_oe_o   = is_read(bus.dm_web_i);
            bus.sram_web_o  = bus.dm_web_i;
            bus.sram_addr_o = bus.dm_addr_i[SRAM_AW+1:2];
            bus.sram_di_o   = bus.dm_wdata_i;
            owner_d         = is_read(bus.dm_web_i) ? OWN_DM : OWN_NONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q    <= OWN_NONE;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            owner_q <= owner_d;
            if (owner_q == OWN_IF) if_rdata_q <= bus.sram_do_i;
            if (owner_q == OWN_DM) dm_rdata_q <= bus.sram_do_i;
        end
    end

    // During the return cycle the SRAM output is forwarded directly; afterwards the captured copy holds.
    assign bus.if_rvalid_o = (owner_q == OWN_IF);
    assign bus.dm_rvalid_o = (owner_q == OWN_DM);
    assign bus.if_rdata_o  = bus.if_rvalid_o ? bus.sram_do_i : if_rdata_q;
    assign bus.dm_rdata_o  = bus.dm_rvalid_o ? bus.sram_do_i : dm_rdata_q;

    assign bus.if_gnt_o = if_gnt;
    assign bus.dm_gnt_o = dm_gnt;
    assign bus.stall_o  = (bus.if_req_i & ~if_gnt) | (bus.dm_req_i & ~dm_gnt)
                        | (owner_q != OWN_NONE);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized scoreboard bench for sram_port_arbiter with a transaction-level memory model.
module tb_sram_port_arbiter;
    import mem_arb_pkg::*;

    localparam int ADDR_W        = 16;
    localparam int SRAM_AW       = 14;
    localparam int MAX_DM_STREAK = 4;
    localparam int DEPTH         = 1 << SRAM_AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_port_arbiter_if #(.ADDR_W(ADDR_W), .SRAM_AW(SRAM_AW)) bus ();

    sram_port_arbiter #(
        .ADDR_W(ADDR_W), .SRAM_AW(SRAM_AW), .MAX_DM_STREAK(MAX_DM_STREAK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] sram_mem [DEPTH];
    logic [31:0] golden   [DEPTH];

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] web);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (!web[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    // Behavioural SRAM macro: registered read data, byte-masked writes.
    always @(posedge clk) begin
        if (bus.sram_cs_o) begin
            if (bus.sram_web_o != WEB_NONE)
                sram_mem[bus.sram_addr_o] <= merge(sram_mem[bus.sram_addr_o], bus.sram_di_o, bus.sram_web_o);
            if (bus.sram_oe_o) bus.sram_do_i <= sram_mem[bus.sram_addr_o];
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic [31:0] if_q [$];
    logic [31:0] dm_q [$];

    // Monitor: whenever the DUT presents read data, pop the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.if_rvalid_o) begin
            if (if_q.size() == 0) check("if_rvalid_unexpected", 32'd1, 32'd0);
            else check("if_rdata", bus.if_rdata_o, if_q.pop_front());
        end
        if (!rst && bus.dm_rvalid_o) begin
            if (dm_q.size() == 0) check("dm_rvalid_unexpected", 32'd1, 32'd0);
            else check("dm_rdata", bus.dm_rdata_o, dm_q.pop_front());
        end
    end

    // Reference model state, kept at transaction level.
    int          m_run;
    bit          m_if_rd, m_dm_rd;
    logic [31:0] m_if_pend, m_dm_pend, m_if_last, m_dm_last;

    task automatic model_reset();
        m_run = 0; m_if_rd = 0; m_dm_rd = 0;
        m_if_pend = '0; m_dm_pend = '0; m_if_last = '0; m_dm_last = '0;
        if_q.delete(); dm_q.delete();
    endtask

    task automatic drive(input bit ir, input logic [15:0] ia, input bit dr, input logic [15:0] da,
                         input logic [3:0] dw, input logic [31:0] dd);
        bus.if_req_i   = ir;
        bus.if_addr_i  = ia;
        bus.dm_req_i   = dr;
        bus.dm_addr_i  = da;
        bus.dm_web_i   = dw;
        bus.dm_wdata_i = dd;
    endtask

    task automatic step(input bit ir, input logic [15:0] ia, input bit dr, input logic [15:0] da,
                        input logic [3:0] dw, input logic [31:0] dd, output bit eg_if, output bit eg_dm);
        int ii, di;
        logic [31:0] e_addr;
        @(posedge clk);
        #1;
        drive(ir, ia, dr, da, dw, dd);
        @(negedge clk);
        ii = int'(ia) / 4 % DEPTH;
        di = int'(da) / 4 % DEPTH;
        eg_if = ir && (!dr || m_run >= MAX_DM_STREAK);
        eg_dm = dr && !eg_if;
        e_addr = eg_if ? ii : (eg_dm ? di : 0);
        check("if_gnt",    32'(bus.if_gnt_o), 32'(eg_if));
        check("dm_gnt",    32'(bus.dm_gnt_o), 32'(eg_dm));
        check("sram_cs",   32'(bus.sram_cs_o), 32'(eg_if || eg_dm));
        check("sram_oe",   32'(bus.sram_oe_o), 32'(eg_if || (eg_dm && dw == WEB_NONE)));
        check("sram_web",  32'(bus.sram_web_o), 32'(eg_dm ? dw : WEB_NONE));
        check("sram_addr", 32'(bus.sram_addr_o), e_addr);
        check("sram_di",   bus.sram_di_o, eg_dm ? dd : 32'd0);
        check("stall",     32'(bus.stall_o),
              32'((ir && !eg_if) || (dr && !eg_dm) || m_if_rd || m_dm_rd));
        check("if_rvalid", 32'(bus.if_rvalid_o), 32'(m_if_rd));
        check("dm_rvalid", 32'(bus.dm_rvalid_o), 32'(m_dm_rd));
        if (m_if_rd) m_if_last = m_if_pend; else check("if_rdata_hold", bus.if_rdata_o, m_if_last);
        if (m_dm_rd) m_dm_last = m_dm_pend; else check("dm_rdata_hold", bus.dm_rdata_o, m_dm_last);
        if (eg_if) begin
            m_if_pend = golden[ii];
            if_q.push_back(m_if_pend);
        end
        if (eg_dm) begin
            if (dw == WEB_NONE) begin
                m_dm_pend = golden[di];
                dm_q.push_back(m_dm_pend);
            end else begin
                golden[di] = merge(golden[di], dd, dw);
            end
        end
        m_run   = (eg_dm && ir) ? ((m_run + 1 > MAX_DM_STREAK) ? MAX_DM_STREAK : m_run + 1) : 0;
        m_if_rd = eg_if;
        m_dm_rd = eg_dm && dw == WEB_NONE;
    endtask

    task automatic idle(input int n);
        bit gi, gd;
        repeat (n) step(1'b0, 16'h0, 1'b0, 16'h0, WEB_NONE, 32'h0, gi, gd);
    endtask

    function automatic logic [15:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return 16'($urandom);
        return 16'($urandom_range(0, 127));
    endfunction

    function automatic logic [3:0] rand_web();
        case ($urandom_range(0, 4))
            0, 1:    return WEB_NONE;
            2:       return WEB_BYTE;
            3:       return WEB_HALF;
            default: return 4'($urandom);
        endcase
    endfunction

    initial begin
        bit gi, gd;
        bit p_if, p_dm;
        logic [15:0] a_if, a_dm;
        logic [3:0]  w_dm;
        logic [31:0] d_dm;
        string order;

        for (int i = 0; i < DEPTH; i++) begin
            golden[i]   = $urandom;
            sram_mem[i] = golden[i];
        end
        golden[0] = 32'd1; golden[1] = 32'd2; golden[2] = 32'd3; golden[4] = 32'hDEADBEEF;
        sram_mem[0] = 32'd1; sram_mem[1] = 32'd2; sram_mem[2] = 32'd3; sram_mem[4] = 32'hDEADBEEF;
        bus.sram_do_i = '0;
        drive(1'b0, 16'h0, 1'b0, 16'h0, WEB_NONE, 32'h0);
        model_reset();

        // Reset state
        @(negedge clk);
        check("rst_if_rvalid", 32'(bus.if_rvalid_o), 32'd0);
        check("rst_dm_rvalid", 32'(bus.dm_rvalid_o), 32'd0);
        check("rst_if_rdata",  bus.if_rdata_o, 32'd0);
        check("rst_dm_rdata",  bus.dm_rdata_o, 32'd0);
        check("rst_cs",        32'(bus.sram_cs_o), 32'd0);
        check("rst_web",       32'(bus.sram_web_o), 32'(WEB_NONE));
        check("rst_stall",     32'(bus.stall_o), 32'd0);
        rst = 1'b0;

        // IF only: word 4 returns DEADBEEF next cycle
        step(1'b1, 16'h0010, 1'b0, 16'h0, WEB_NONE, 32'h0, gi, gd);
        idle(1);

        // Contention: DM read wins, IF follows
        step(1'b1, 16'h0000, 1'b1, 16'h0100, WEB_NONE, 32'h0, gi, gd);
        step(1'b1, 16'h0000, 1'b0, 16'h0, WEB_NONE, 32'h0, gi, gd);
        idle(1);

        // Store byte, no rvalid afterwards
        step(1'b0, 16'h0, 1'b1, 16'h0203, WEB_BYTE, 32'h000000AB, gi, gd);
        idle(2);

        // Back-to-back IF reads returning 1, 2, 3
        step(1'b1, 16'h0000, 1'b0, 16'h0, WEB_NONE, 32'h0, gi, gd);
        step(1'b1, 16'h0004, 1'b0, 16'h0, WEB_NONE, 32'h0, gi, gd);
        step(1'b1, 16'h0008, 1'b0, 16'h0, WEB_NONE, 32'h0, gi, gd);
        idle(2);

        // Starvation: both held for 7 cycles
        order = "";
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 16'h0040, 1'b1, 16'h0044, WEB_NONE, 32'h0, gi, gd);
            order = {order, bus.dm_gnt_o ? "D" : (bus.if_gnt_o ? "I" : "-")};
        end
        n_cmp++;
        if (order != "DDDDIDD") begin
            n_err++;
            $display("FAIL starvation_order: got %s, expected DDDDIDD", order);
        end
        idle(2);

        // Reset mid-read: the granted IF read must never return
        step(1'b1, 16'h0020, 1'b0, 16'h0, WEB_NONE, 32'h0, gi, gd);
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        drive(1'b0, 16'h0, 1'b0, 16'h0, WEB_NONE, 32'h0);
        @(negedge clk);
        check("rstmid_if_rvalid", 32'(bus.if_rvalid_o), 32'd0);
        check("rstmid_if_rdata",  bus.if_rdata_o, 32'd0);
        check("rstmid_stall",     32'(bus.stall_o), 32'd0);
        rst = 1'b0;
        idle(1);

        // Randomized traffic with requests held until granted
        p_if = 0; p_dm = 0;
        a_if = '0; a_dm = '0; w_dm = WEB_NONE; d_dm = '0;
        repeat (400) begin
            if (!p_if && $urandom_range(0, 2) != 0) begin
                p_if = 1; a_if = rand_addr();
            end
            if (!p_dm && $urandom_range(0, 2) != 0) begin
                p_dm = 1; a_dm = rand_addr(); w_dm = rand_web(); d_dm = $urandom;
            end
            step(p_if, a_if, p_dm, a_dm, w_dm, d_dm, gi, gd);
            if (gi) p_if = 0;
            if (gd) p_dm = 0;
        end
        idle(3);

        check("if_q_drained", 32'(if_q.size()), 32'd0);
        check("dm_q_drained", 32'(dm_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
